// File: rtl/acq_seq_pkg.sv
//------------------------------------------------------------------------------
// Module : acq_seq_pkg
// Brief  : Shared state encoding and default sizing for the acquisition sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package acq_seq_pkg;

    localparam int C_NUM_CH      = 4;
    localparam int C_CH_W        = 2;
    localparam int C_DATA_W      = 16;
    localparam int C_TIMEOUT_CYC = 1000;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_SCAN = 2'd1;
    localparam logic [1:0] C_ST_WAIT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = C_ST_IDLE,
        S_SCAN = C_ST_SCAN,
        S_WAIT = C_ST_WAIT
    } state_t;

endpackage

`default_nettype wire

// File: rtl/acq_sequencer_lsb_pick.sv
//------------------------------------------------------------------------------
// Module : lsb_pick
// Brief  : Combinational lowest-set-bit finder over a channel mask.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsb_pick #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] mask,
    output logic              any,
    output logic [CH_W-1:0]   idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                any = 1'b1;
                idx = CH_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/acq_sequencer.sv
//------------------------------------------------------------------------------
// Module : acq_sequencer
// Brief  : Per-sample-period channel walker driving one shared converter.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module acq_sequencer
    import acq_seq_pkg::*;
#(
    parameter int NUM_CH      = C_NUM_CH,
    parameter int CH_W        = C_CH_W,
    parameter int DATA_W      = C_DATA_W,
    parameter int TIMEOUT_CYC = C_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              err_clr,
    output logic              conv_start,
    output logic [CH_W-1:0]   conv_ch,
    input  logic              conv_done,
    input  logic [DATA_W-1:0] conv_data,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              round_ok,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int              C_TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(TIMEOUT_CYC - 1);

    state_t              r_state;
    logic [NUM_CH-1:0]   r_pending;
    logic [C_TMR_W-1:0]  r_timer;
    logic                r_tout_seen;

    logic                w_any;
    logic [CH_W-1:0]     w_idx;
    logic [NUM_CH-1:0]   w_onehot;
    logic                w_set_ovr;
    logic                w_set_tout;

    lsb_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_lsb_pick (
        .mask (r_pending),
        .any  (w_any),
        .idx  (w_idx)
    );

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_onehot[i] = (w_idx == CH_W'(i));
        end
    end

    // A done on the terminal WAIT cycle takes priority over the timeout.
    assign w_set_ovr  = ce && (r_state != S_IDLE);
    assign w_set_tout = (r_state == S_WAIT) && !conv_done && (r_timer == C_TMR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_timer     <= '0;
            r_tout_seen <= 1'b0;
            conv_start  <= 1'b0;
            conv_ch     <= '0;
            out_valid   <= 1'b0;
            out_ch      <= '0;
            out_data    <= '0;
            busy        <= 1'b0;
            round_ok    <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            conv_start <= 1'b0;
            out_valid  <= 1'b0;
            round_ok   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (ce) begin
                        r_pending   <= ch_enable;
                        r_tout_seen <= 1'b0;
                        r_state     <= S_SCAN;
                        busy        <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_any) begin
                        r_pending  <= r_pending & ~w_onehot;
                        conv_start <= 1'b1;
                        conv_ch    <= w_idx;
                        r_timer    <= '0;
                        r_state    <= S_WAIT;
                    end else begin
                        round_ok <= !r_tout_seen;
                        r_state  <= S_IDLE;
                        busy     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (conv_done) begin
                        out_valid <= 1'b1;
                        out_ch    <= conv_ch;
                        out_data  <= conv_data;
                        r_state   <= S_SCAN;
                    end else if (r_timer == C_TMR_LAST) begin
                        r_tout_seen <= 1'b1;
                        r_state     <= S_SCAN;
                    end else begin
                        r_timer <= r_timer + C_TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase

            overrun     <= w_set_ovr  | (overrun     & ~err_clr);
            timeout_err <= w_set_tout | (timeout_err & ~err_clr);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_acq_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_acq_sequencer
// Brief  : Directed self-checking bench for acq_sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_acq_sequencer;

    localparam int NUM_CH      = 4;
    localparam int CH_W        = 2;
    localparam int DATA_W      = 16;
    localparam int TIMEOUT_CYC = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ce;
    logic [NUM_CH-1:0] ch_enable;
    logic              err_clr;
    logic              conv_start;
    logic [CH_W-1:0]   conv_ch;
    logic              conv_done;
    logic [DATA_W-1:0] conv_data;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              round_ok;
    logic              overrun;
    logic              timeout_err;

    acq_sequencer #(
        .NUM_CH      (NUM_CH),
        .CH_W        (CH_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .ch_enable   (ch_enable),
        .err_clr     (err_clr),
        .conv_start  (conv_start),
        .conv_ch     (conv_ch),
        .conv_done   (conv_done),
        .conv_data   (conv_data),
        .out_valid   (out_valid),
        .out_ch      (out_ch),
        .out_data    (out_data),
        .busy        (busy),
        .round_ok    (round_ok),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int n_start, n_out, rok_cyc, idle_cyc, tout_cyc;
    int start_cyc [8];
    int start_ch  [8];
    int out_cyc   [8];
    int out_tag   [8];
    int out_val   [8];
    int ovr_hist  [64];

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the cycle ce is presented; the converter answers lat cycles
    // after each start (lat=0 means it never answers).
    task automatic run_round(input logic [NUM_CH-1:0] mask, input int lat,
                             input int ce_at, input int clr_at, input int both_at,
                             input int max_cyc);
        int  cyc;
        int  done_at;
        int  cur_ch;
        bit  running;
        n_start = 0; n_out = 0; rok_cyc = -1; idle_cyc = -1; tout_cyc = -1;
        done_at = -1; cur_ch = 0; running = 1'b1;
        for (int i = 0; i < 64; i++) ovr_hist[i] = 0;
        ce = 1'b1; ch_enable = mask;
        tick;
        ce = 1'b0; ch_enable = ~mask;
        cyc = 1;
        while (running) begin
            if (conv_start) begin
                cur_ch = int'(conv_ch);
                if (n_start < 8) begin
                    start_cyc[n_start] = cyc; start_ch[n_start] = cur_ch;
                    n_start++;
                end
                if (lat > 0) done_at = cyc + lat;
            end
            if (out_valid && n_out < 8) begin
                out_cyc[n_out] = cyc; out_tag[n_out] = int'(out_ch);
                out_val[n_out] = int'(out_data);
                n_out++;
            end
            if (round_ok && rok_cyc < 0) rok_cyc = cyc;
            if (timeout_err && tout_cyc < 0) tout_cyc = cyc;
            ovr_hist[cyc] = int'(overrun);
            if (!busy) begin
                idle_cyc = cyc;
                running  = 1'b0;
            end else if (cyc >= max_cyc) begin
                check_val("round_bound", cyc, -1);
                running = 1'b0;
            end else begin
                conv_done = (cyc == done_at);
                conv_data = 16'h1000 + 16'(cur_ch);
                ce        = (cyc == ce_at) || (cyc == both_at);
                err_clr   = (cyc == clr_at) || (cyc == both_at);
                tick;
                cyc++;
            end
        end
        conv_done = 1'b0; ce = 1'b0; err_clr = 1'b0;
    endtask

    task automatic check_full_round(input string pfx);
        check_val({pfx, "_nstart"}, n_start, 3);
        check_val({pfx, "_s0_cyc"}, start_cyc[0], 2);
        check_val({pfx, "_s0_ch"},  start_ch[0], 0);
        check_val({pfx, "_s1_cyc"}, start_cyc[1], 7);
        check_val({pfx, "_s1_ch"},  start_ch[1], 1);
        check_val({pfx, "_s2_cyc"}, start_cyc[2], 12);
        check_val({pfx, "_s2_ch"},  start_ch[2], 3);
        check_val({pfx, "_nout"},   n_out, 3);
        check_val({pfx, "_o0_cyc"}, out_cyc[0], 6);
        check_val({pfx, "_o0_tag"}, out_tag[0], 0);
        check_val({pfx, "_o0_dat"}, out_val[0], 32'h1000);
        check_val({pfx, "_o1_tag"}, out_tag[1], 1);
        check_val({pfx, "_o1_dat"}, out_val[1], 32'h1001);
        check_val({pfx, "_o2_cyc"}, out_cyc[2], 16);
        check_val({pfx, "_o2_tag"}, out_tag[2], 3);
        check_val({pfx, "_o2_dat"}, out_val[2], 32'h1003);
        check_val({pfx, "_rok"},    rok_cyc, 17);
        check_val({pfx, "_idle"},   idle_cyc, 17);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; ch_enable = '0; err_clr = 1'b0;
        conv_done = 1'b0; conv_data = '0;
        repeat (3) tick;
        check_val("rst_conv_start", int'(conv_start), 0);
        check_val("rst_conv_ch",    int'(conv_ch), 0);
        check_val("rst_out_valid",  int'(out_valid), 0);
        check_val("rst_out_ch",     int'(out_ch), 0);
        check_val("rst_out_data",   int'(out_data), 0);
        check_val("rst_busy",       int'(busy), 0);
        check_val("rst_round_ok",   int'(round_ok), 0);
        check_val("rst_overrun",    int'(overrun), 0);
        check_val("rst_timeout",    int'(timeout_err), 0);
        rst = 1'b0;
        tick;

        // Mask 1011, converter latency 3
        run_round(4'b1011, 3, -1, -1, -1, 40);
        check_full_round("m1011");
        check_val("m1011_tout", tout_cyc, -1);

        // All-zero mask, issued back-to-back on the idle cycle
        run_round(4'b0000, 3, -1, -1, -1, 40);
        check_val("m0_nstart", n_start, 0);
        check_val("m0_rok",    rok_cyc, 2);
        check_val("m0_idle",   idle_cyc, 2);

        // Silent converter
        run_round(4'b0001, 0, -1, -1, -1, 40);
        check_val("to_nstart", n_start, 1);
        check_val("to_cyc",    tout_cyc, 10);
        check_val("to_nout",   n_out, 0);
        check_val("to_rok",    rok_cyc, -1);
        check_val("to_idle",   idle_cyc, 11);
        check_val("to_sticky", int'(timeout_err), 1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        check_val("to_cleared", int'(timeout_err), 0);

        // Done on the terminal WAIT cycle
        run_round(4'b0001, 7, -1, -1, -1, 40);
        check_val("term_nout", n_out, 1);
        check_val("term_ocyc", out_cyc[0], 10);
        check_val("term_odat", out_val[0], 32'h1000);
        check_val("term_tout", tout_cyc, -1);
        check_val("term_rok",  rok_cyc, 11);

        // Overrun: ce at 5, clear at 8, clear+ce together at 10
        run_round(4'b1011, 3, 5, 8, 10, 40);
        check_full_round("ovr");
        check_val("ovr_c5",  ovr_hist[5], 0);
        check_val("ovr_c6",  ovr_hist[6], 1);
        check_val("ovr_c9",  ovr_hist[9], 0);
        check_val("ovr_c11", ovr_hist[11], 1);

        // Reset while waiting on channel 2
        ce = 1'b1; ch_enable = 4'b0100;
        tick;
        ce = 1'b0;
        tick;
        check_val("rw_start_ch", int'(conv_ch), 2);
        tick;
        check_val("rw_busy_pre", int'(busy), 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_val("rw_busy",     int'(busy), 0);
        check_val("rw_conv_ch",  int'(conv_ch), 0);
        check_val("rw_out_ch",   int'(out_ch), 0);
        check_val("rw_out_data", int'(out_data), 0);
        check_val("rw_overrun",  int'(overrun), 0);
        check_val("rw_round_ok", int'(round_ok), 0);
        conv_done = 1'b1; conv_data = 16'hBEEF;
        tick;
        conv_done = 1'b0;
        check_val("rw_late_done_valid", int'(out_valid), 0);
        check_val("rw_late_done_data",  int'(out_data), 0);
        run_round(4'b0001, 3, -1, -1, -1, 40);
        check_val("rw_nstart", n_start, 1);
        check_val("rw_s0_cyc", start_cyc[0], 2);
        check_val("rw_s0_ch",  start_ch[0], 0);
        check_val("rw_o0_dat", out_val[0], 32'h1000);
        check_val("rw_rok",    rok_cyc, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
